imem_responder: RTL and testbench

Instruction-memory responder for the LC3 datapath: the memory-side end of the fetch interface. It samples the fetch stage's `pc`/`rd` request and returns the addressed 16-bit instruction after a programmable number of wait states. A one-cycle `complete` pulse marks each response. A side write port preloads program images from the bench or a loader.

---
 rtl/lc3_pkg.sv | 23 ++
 rtl/imem_array.sv | 41 ++++
 rtl/imem_responder.sv | 102 ++++++++++
 tb/tb_imem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC3 types, constants and address-window helper
package lc3_pkg;

    localparam logic [15:0] LC3_RESET_PC  = 16'h3000;
    localparam logic [15:0] LC3_IMEM_FILL = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } imem_state_e;

    // True when base <= a < base + 2^aw, using 16-bit wrapping subtraction.
    function automatic logic in_window(input logic [15:0] a,
                                       input logic [15:0] base,
                                       input int unsigned aw);
        logic [15:0] off;
        off = a - base;
        if (aw >= 16) return 1'b1;
        return (off >> aw) == 16'd0;
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - 2^AW x 16 instruction store, synchronous write-first access
module imem_array
    import lc3_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic          re_i,
    input  logic          rclr_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [0:(1<<AW)-1];
    logic [15:0] rdata_q;

    // Contents survive reset so a preloaded image outlives a core reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 16'h0000;
        end else if (re_i) begin
            if (rclr_i)
                rdata_q <= LC3_IMEM_FILL;
            else if (we_i && (waddr_i == raddr_i))
                rdata_q <= wdata_i;
            else
                rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - LC3 fetch-side memory responder with programmable wait states
module imem_responder
    import lc3_pkg::*;
#(
    parameter int          AW          = 10,
    parameter logic [15:0] BASE        = LC3_RESET_PC,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic [15:0] dout,
    output logic        complete,
    output logic        err
);

    localparam logic [3:0] WCNT_LOAD = 4'(WAIT_STATES);

    imem_state_e   state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [15:0]   cap_addr_q, cap_addr_d;
    logic          complete_q, err_q;
    logic          req, capture, enter_done, rd_in_win, wr_en;
    logic [AW-1:0] rd_idx, wr_idx;

    // Fetch tri-states rd; Z/X fall to the else branch and read as idle.
    always_comb begin
        req = 1'b0;
        if (rd) req = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        cap_addr_d = cap_addr_q;
        capture    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (req) capture = 1'b1;
                else     state_d = IDLE;
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    wcnt_d  = 4'd0;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            cap_addr_d = addr;
            wcnt_d     = WCNT_LOAD;
            state_d    = (WAIT_STATES == 0) ? DONE : WAIT;
        end
    end

    // The read targets the next captured address so zero-wait requests hit the same edge.
    assign enter_done = (state_d == DONE);
    assign rd_in_win  = in_window(cap_addr_d, BASE, AW);
    assign rd_idx     = AW'(cap_addr_d - BASE);
    assign wr_en      = ld_en && in_window(ld_addr, BASE, AW);
    assign wr_idx     = AW'(ld_addr - BASE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= 4'd0;
            cap_addr_q <= 16'h0000;
            complete_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            cap_addr_q <= cap_addr_d;
            complete_q <= enter_done;
            err_q      <= enter_done && !rd_in_win;
        end
    end

    imem_array #(.AW(AW)) u_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_idx),
        .wdata_i (ld_data),
        .re_i    (enter_done),
        .rclr_i  (!rd_in_win),
        .raddr_i (rd_idx),
        .rdata_o (dout)
    );

    assign complete = complete_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int BASE  = 'h3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [15:0] ld_addr, ld_data;
    logic        rd0, rd1, rd3;
    logic [15:0] addr0, addr1, addr3;
    logic [15:0] dout0, dout1, dout3;
    logic        cmp0, cmp1, cmp3;
    logic        err0, err1, err3;

    logic [15:0] model_mem [DEPTH];
    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    imem_responder #(.AW(AW), .BASE(16'h3000), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .addr(addr0), .rd(rd0), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .dout(dout0), .complete(cmp0), .err(err0));
    imem_responder #(.AW(AW), .BASE(16'h3000), .WAIT_STATES(1)) u1 (
        .clk(clk), .rst(rst), .addr(addr1), .rd(rd1), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .dout(dout1), .complete(cmp1), .err(err1));
    imem_responder #(.AW(AW), .BASE(16'h3000), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .addr(addr3), .rd(rd3), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .dout(dout3), .complete(cmp3), .err(err3));

    function automatic bit model_in(input int a);
        return (a >= BASE) && (a < BASE + DEPTH);
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (!model_in(int'(a))) return 16'h0000;
        return model_mem[int'(a) - BASE];
    endfunction

    function automatic logic [15:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)  return 16'(BASE + r);
        if (r == 8) return 16'(BASE + DEPTH + $urandom_range(0, 7));
        return 16'(BASE - 1 - $urandom_range(0, 7));
    endfunction

    task automatic tick();
        @(posedge clk);
        if (ld_en && model_in(int'(ld_addr))) model_mem[int'(ld_addr) - BASE] = ld_data;
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        rd0 = 1'b0; rd1 = 1'b0; rd3 = 1'b0;
        addr0 = '0; addr1 = '0; addr3 = '0;
        #1;
        total++; if ({cmp0, cmp1, cmp3} !== 3'b000) $display("FAIL reset_complete: got %b want 000", {cmp0, cmp1, cmp3}); else passed++;
        total++; if ({err0, err1, err3} !== 3'b000) $display("FAIL reset_err: got %b want 000", {err0, err1, err3}); else passed++;
        total++; if ({dout0, dout1, dout3} !== 48'h0) $display("FAIL reset_dout: got %h want 0", {dout0, dout1, dout3}); else passed++;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (cmp1 !== 1'b0) $display("FAIL idle_after_reset: got %b want 0", cmp1); else passed++;
    endtask

    task automatic test_single();
        preload(16'h3000, 16'h1234);
        rd1 = 1'b1; addr1 = 16'h3000;
        tick();
        total++; if (cmp1 !== 1'b0) $display("FAIL single_early: got %b want 0", cmp1); else passed++;
        addr1 = 16'(($urandom));
        tick();
        rd1 = 1'b0;
        total++; if (cmp1 !== 1'b1) $display("FAIL single_complete: got %b want 1", cmp1); else passed++;
        total++; if (dout1 !== 16'h1234) $display("FAIL single_dout: got %h want 1234", dout1); else passed++;
        total++; if (err1 !== 1'b0) $display("FAIL single_err: got %b want 0", err1); else passed++;
        tick();
        total++; if (cmp1 !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", cmp1); else passed++;
        total++; if (dout1 !== 16'h1234) $display("FAIL single_dout_hold: got %h want 1234", dout1); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) preload(16'(BASE + i), 16'($urandom));
        rd1 = 1'b1; addr1 = 16'h3000;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (cmp1 !== 1'b0) $display("FAIL b2b_wait_%0d: got %b want 0", i, cmp1); else passed++;
            addr1 = 16'($urandom);
            tick();
            total++; if (cmp1 !== 1'b1) $display("FAIL b2b_complete_%0d: got %b want 1", i, cmp1); else passed++;
            total++; if (dout1 !== model_mem[i]) $display("FAIL b2b_dout_%0d: got %h want %h", i, dout1, model_mem[i]); else passed++;
            addr1 = 16'(BASE + i + 1);
            if (i == 7) rd1 = 1'b0;
        end
        tick();
        total++; if (cmp1 !== 1'b0) $display("FAIL b2b_end_idle: got %b want 0", cmp1); else passed++;
    endtask

    task automatic test_window();
        logic [15:0] addrs [6];
        preload(16'h33FF, 16'hBEEF);
        preload(16'h3000, 16'hC0DE);
        preload(16'h2FFF, 16'hDEAD);
        preload(16'h3400, 16'hFACE);
        addrs[0] = 16'h2FFF;
        addrs[1] = 16'h3400;
        addrs[2] = 16'($urandom_range(0, 'h2FFF));
        addrs[3] = 16'($urandom_range('h3400, 'hFFFF));
        addrs[4] = 16'h33FF;
        addrs[5] = 16'h3000;
        for (int i = 0; i < 6; i++) begin
            rd1 = 1'b1; addr1 = addrs[i];
            tick();
            tick();
            rd1 = 1'b0;
            total++; if (cmp1 !== 1'b1) $display("FAIL win_complete_%0h: got %b want 1", addrs[i], cmp1); else passed++;
            total++; if (dout1 !== model_read(addrs[i])) $display("FAIL win_dout_%0h: got %h want %h", addrs[i], dout1, model_read(addrs[i])); else passed++;
            total++; if (err1 !== !model_in(int'(addrs[i]))) $display("FAIL win_err_%0h: got %b want %b", addrs[i], err1, !model_in(int'(addrs[i]))); else passed++;
            tick();
        end
    endtask

    task automatic test_abort();
        preload(16'h3010, 16'h7777);
        rd3 = 1'b1; addr3 = 16'h3010;
        tick();
        tick();
        rd3 = 1'bz;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (cmp3 !== 1'b0) $display("FAIL abort_no_complete_%0d: got %b want 0", i, cmp3); else passed++;
        end
        rd3 = 1'b1; addr3 = 16'h3010;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (cmp3 !== 1'b0) $display("FAIL ws3_early_%0d: got %b want 0", i, cmp3); else passed++;
        end
        tick();
        rd3 = 1'b0;
        total++; if (cmp3 !== 1'b1) $display("FAIL ws3_complete: got %b want 1", cmp3); else passed++;
        total++; if (dout3 !== 16'h7777) $display("FAIL ws3_dout: got %h want 7777", dout3); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        rd3 = 1'b1; addr3 = 16'h3010;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        total++; if (cmp3 !== 1'b0) $display("FAIL arst_complete: got %b want 0", cmp3); else passed++;
        total++; if (dout3 !== 16'h0000) $display("FAIL arst_dout3: got %h want 0000", dout3); else passed++;
        total++; if (dout1 !== 16'h0000) $display("FAIL arst_dout1: got %h want 0000", dout1); else passed++;
        total++; if (err3 !== 1'b0) $display("FAIL arst_err: got %b want 0", err3); else passed++;
        rd3 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        total++; if (cmp3 !== 1'b0) $display("FAIL arst_no_complete: got %b want 0", cmp3); else passed++;
        rd3 = 1'b1;
        repeat (4) tick();
        rd3 = 1'b0;
        total++; if (cmp3 !== 1'b1) $display("FAIL arst_retry_complete: got %b want 1", cmp3); else passed++;
        total++; if (dout3 !== 16'h7777) $display("FAIL arst_mem_kept: got %h want 7777", dout3); else passed++;
        tick();
    endtask

    task automatic test_ws0();
        preload(16'h3005, 16'hAAAA);
        ld_en = 1'b1; ld_addr = 16'h3005; ld_data = 16'h5555;
        rd0 = 1'b1; addr0 = 16'h3005;
        tick();
        ld_en = 1'b0;
        total++; if (cmp0 !== 1'b1) $display("FAIL ws0_complete: got %b want 1", cmp0); else passed++;
        total++; if (dout0 !== 16'h5555) $display("FAIL ws0_write_first: got %h want 5555", dout0); else passed++;
        for (int i = 0; i < 4; i++) begin
            addr0 = 16'(BASE + i);
            tick();
            total++; if (cmp0 !== 1'b1) $display("FAIL ws0_b2b_complete_%0d: got %b want 1", i, cmp0); else passed++;
            total++; if (dout0 !== model_mem[i]) $display("FAIL ws0_b2b_dout_%0d: got %h want %h", i, dout0, model_mem[i]); else passed++;
        end
        rd0 = 1'b0;
        tick();
        total++; if (cmp0 !== 1'b0) $display("FAIL ws0_idle: got %b want 0", cmp0); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int t = 0; t < 40; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                rd1 = 1'b0;
                ld_en = 1'($urandom_range(0, 1)); ld_addr = pick_addr(); ld_data = 16'($urandom);
                tick();
                total++; if (cmp1 !== 1'b0) $display("FAIL rnd_idle_%0d: got %b want 0", t, cmp1); else passed++;
            end
            a = pick_addr();
            rd1 = 1'b1; addr1 = a;
            ld_en = 1'($urandom_range(0, 1)); ld_addr = pick_addr(); ld_data = 16'($urandom);
            tick();
            total++; if (cmp1 !== 1'b0) $display("FAIL rnd_wait_%0d: got %b want 0", t, cmp1); else passed++;
            addr1 = 16'($urandom);
            ld_en = 1'($urandom_range(0, 1)); ld_addr = (($urandom_range(0, 1) == 1) ? a : pick_addr()); ld_data = 16'($urandom);
            tick();
            total++; if (cmp1 !== 1'b1) $display("FAIL rnd_complete_%0d: got %b want 1", t, cmp1); else passed++;
            total++; if (dout1 !== model_read(a)) $display("FAIL rnd_dout_%0d addr %h: got %h want %h", t, a, dout1, model_read(a)); else passed++;
            total++; if (err1 !== !model_in(int'(a))) $display("FAIL rnd_err_%0d addr %h: got %b want %b", t, a, err1, !model_in(int'(a))); else passed++;
        end
        rd1 = 1'b0; ld_en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_window();
        test_abort();
        test_async_reset();
        test_ws0();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
